fwd_scoreboard: RTL and testbench

Parametrised in-flight destination scoreboard for the pipelined ARM core, sitting between decode and the operand-forwarding muxes. It tracks the destination register, write-enable and load flag of every instruction in stages 1..DEPTH (EX, MEM, WB by default). From that state it computes, per source operand, which stage to forward from. It also raises a load-use hazard that stalls decode. It generalises the fixed two-source, three-stage forwarding and control-queue logic to any depth, source count and load latency, and adds stall, flush and bubble handling.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_match.sv | 35 +++
 rtl/fwd_scoreboard.sv | 125 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the in-flight destination scoreboard.
// Stage entries keep rd at SB_RD_W bits, so REG_W may be up to 8.
package fwd_pkg;

  localparam int SB_RD_W      = 8;
  localparam int ZERO_REG_DEF = 31;

  typedef struct packed {
    logic               valid;
    logic               wr;
    logic               ld;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search of the tracked stages for one source operand: the youngest
// matching writer wins; a load that is too young raises a hazard instead.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = ZERO_REG_DEF,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = sel_width(DEPTH)
) (
  input  sb_entry_t        stage [DEPTH],
  input  logic [REG_W-1:0] src,
  output logic [SEL_W-1:0] sel,
  output logic             hazard
);

  logic found;

  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    // stage[0] is EX (stage 1); scanning upward lets the first hit shadow older writers
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && stage[k].valid && stage[k].wr &&
          stage[k].rd == SB_RD_W'(src) && src != REG_W'(ZERO_REG)) begin
        found = 1'b1;
        if (stage[k].ld && (k + 1) < LOAD_READY) hazard = 1'b1;
        else                                     sel    = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight destination scoreboard: tracks stages 1..DEPTH and drives operand
// forward selects and the load-use hazard. FWD_SCOREBOARD_STATS_EN adds counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = ZERO_REG_DEF,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic                     issue_ld,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [NUM_SRC*REG_W-1:0] src_idx,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     hazard,
  output logic                     busy,
  output logic [SEL_W-1:0]         inflight,
  output logic [15:0]              stat_hazard_cnt,
  output logic [15:0]              stat_fwd_cnt
);

  logic             vld_q [DEPTH];
  logic             wr_q  [DEPTH];
  logic             ld_q  [DEPTH];
  logic [REG_W-1:0] rd_q  [DEPTH];
  sb_entry_t        stage [DEPTH];
  logic [NUM_SRC-1:0] ch_hazard;
  logic             issue_ok;

  // Any blocking condition turns the issue slot into a single bubble
  assign issue_ok = issue_valid & ~stall & ~flush & ~hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '{default: 1'b0};
    end else begin
      vld_q[0] <= issue_ok;
      for (int k = 1; k < DEPTH; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // Payload is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    wr_q[0] <= issue_wr;
    ld_q[0] <= issue_ld;
    rd_q[0] <= issue_rd;
    for (int k = 1; k < DEPTH; k++) begin
      wr_q[k] <= wr_q[k-1];
      ld_q[k] <= ld_q[k-1];
      rd_q[k] <= rd_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage[k].valid = vld_q[k];
      stage[k].wr    = wr_q[k];
      stage[k].ld    = ld_q[k];
      stage[k].rd    = SB_RD_W'(rd_q[k]);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .DEPTH      (DEPTH),
      .REG_W      (REG_W),
      .ZERO_REG   (ZERO_REG),
      .LOAD_READY (LOAD_READY),
      .SEL_W      (SEL_W)
    ) u_match (
      .stage  (stage),
      .src    (src_idx[i*REG_W +: REG_W]),
      .sel    (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard (ch_hazard[i])
    );
  end

  assign hazard = |ch_hazard;

  always_comb begin
    busy     = 1'b0;
    inflight = '0;
    for (int k = 0; k < DEPTH; k++) begin
      busy     = busy | vld_q[k];
      inflight = inflight + SEL_W'(vld_q[k]);
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [15:0] hz_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic        fwd_any;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  assign fwd_any = |fwd_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hz_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      hz_cnt_q  <= sat_inc(hz_cnt_q, hazard);
      fwd_cnt_q <= sat_inc(fwd_cnt_q, fwd_any);
    end
  end

  assign stat_hazard_cnt = hz_cnt_q;
  assign stat_fwd_cnt    = fwd_cnt_q;
`else
  assign stat_hazard_cnt = 16'h0000;
  assign stat_fwd_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomised and directed bench for fwd_scoreboard against an in-bench
// reference model of the stage history.
module tb_fwd_scoreboard;

  localparam int DEPTH      = 3;
  localparam int NUM_SRC    = 2;
  localparam int REG_W      = 5;
  localparam int LOAD_READY = 2;
  localparam int SEL_W      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic                     issue_valid, issue_wr, issue_ld;
  logic [REG_W-1:0]         issue_rd;
  logic                     stall, flush;
  logic [NUM_SRC*REG_W-1:0] src_idx;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     hazard, busy;
  logic [SEL_W-1:0]         inflight;
  logic [15:0]              stat_hazard_cnt, stat_fwd_cnt;

  fwd_scoreboard #(
    .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .REG_W(REG_W), .ZERO_REG(31), .LOAD_READY(LOAD_READY)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_ld(issue_ld), .issue_rd(issue_rd), .stall(stall), .flush(flush),
    .src_idx(src_idx), .fwd_sel(fwd_sel), .hazard(hazard), .busy(busy),
    .inflight(inflight), .stat_hazard_cnt(stat_hazard_cnt), .stat_fwd_cnt(stat_fwd_cnt)
  );

`ifdef FWD_SCOREBOARD_STATS_EN
  logic        sat_reset;
  logic [4:0]  sat_fwd_sel, sat_inflight;
  logic        sat_hazard, sat_busy;
  logic [15:0] sat_hz_cnt, sat_fwd_cnt;

  fwd_scoreboard #(
    .DEPTH(16), .NUM_SRC(1), .REG_W(5), .ZERO_REG(31), .LOAD_READY(16)
  ) u_sat (
    .clk(clk), .reset(sat_reset), .issue_valid(1'b1), .issue_wr(1'b1),
    .issue_ld(1'b1), .issue_rd(5'd3), .stall(1'b0), .flush(1'b0),
    .src_idx(5'd3), .fwd_sel(sat_fwd_sel), .hazard(sat_hazard), .busy(sat_busy),
    .inflight(sat_inflight), .stat_hazard_cnt(sat_hz_cnt), .stat_fwd_cnt(sat_fwd_cnt)
  );
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: history of what occupied each stage slot
  bit         mv  [1:DEPTH];
  bit         mw  [1:DEPTH];
  bit         mld [1:DEPTH];
  logic [4:0] mrd [1:DEPTH];
  logic [4:0] m_src [NUM_SRC];
  int         m_sel [NUM_SRC];
  bit         m_hz;
  int         m_fcnt, m_hcnt;
  bit         rst_lvl;

  task automatic model_clear();
    for (int k = 1; k <= DEPTH; k++) mv[k] = 1'b0;
    m_fcnt = 0;
    m_hcnt = 0;
  endtask

  task automatic model_eval();
    m_hz = 1'b0;
    for (int ch = 0; ch < NUM_SRC; ch++) begin
      bit found;
      found = 1'b0;
      m_sel[ch] = 0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!found && mv[k] && mw[k] && mrd[k] == m_src[ch] && m_src[ch] != 5'd31) begin
          found = 1'b1;
          if (mld[k] && k < LOAD_READY) m_hz = 1'b1;
          else                          m_sel[ch] = k;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input bit w, input bit ld, input logic [4:0] rd,
                       input bit st, input bit fl, input logic [4:0] s0, input logic [4:0] s1);
    int cnt;
    bit any;
    @(negedge clk);
    reset       = rst_lvl;
    issue_valid = v;
    issue_wr    = w;
    issue_ld    = ld;
    issue_rd    = rd;
    stall       = st;
    flush       = fl;
    src_idx     = {s1, s0};
    m_src[0]    = s0;
    m_src[1]    = s1;
    #1;
    if (!rst_lvl) model_clear();
    model_eval();
    cnt = 0;
    any = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      cnt += int'(mv[k]);
      any |= mv[k];
    end
    for (int ch = 0; ch < NUM_SRC; ch++)
      check($sformatf("fwd_sel%0d", ch), 32'(fwd_sel[ch*SEL_W +: SEL_W]), 32'(m_sel[ch]));
    check("hazard", 32'(hazard), 32'(m_hz));
    check("busy", 32'(busy), 32'(any));
    check("inflight", 32'(inflight), 32'(cnt));
`ifdef FWD_SCOREBOARD_STATS_EN
    check("stat_hazard_cnt", 32'(stat_hazard_cnt), 32'(m_hcnt));
    check("stat_fwd_cnt", 32'(stat_fwd_cnt), 32'(m_fcnt));
`else
    check("stat_hazard_cnt", 32'(stat_hazard_cnt), 32'd0);
    check("stat_fwd_cnt", 32'(stat_fwd_cnt), 32'd0);
`endif
  endtask

  task automatic tick();
    bit any_fwd;
    @(posedge clk);
    if (rst_lvl) begin
      any_fwd = 1'b0;
      for (int ch = 0; ch < NUM_SRC; ch++) any_fwd |= (m_sel[ch] != 0);
      if (any_fwd && m_fcnt < 65535) m_fcnt++;
      if (m_hz && m_hcnt < 65535)    m_hcnt++;
      for (int k = DEPTH; k >= 2; k--) begin
        mv[k] = mv[k-1]; mw[k] = mw[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
      end
      mv[1]  = issue_valid & ~stall & ~flush & ~m_hz;
      mw[1]  = issue_wr;
      mld[1] = issue_ld;
      mrd[1] = issue_rd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 5'd0, 0, 0, 5'd31, 5'd31);
      tick();
    end
  endtask

  initial begin
    rst_lvl = 1'b0;
    reset = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0; issue_ld = 1'b0;
    issue_rd = '0; stall = 1'b0; flush = 1'b0; src_idx = '1;
    model_clear();
`ifdef FWD_SCOREBOARD_STATS_EN
    sat_reset = 1'b0;
`endif
    idle(2);
    rst_lvl = 1'b1;
    idle(1);

    // ALU chain: ADD X1 then SUB using X1
    drive(1, 1, 0, 5'd1, 0, 0, 5'd31, 5'd31); tick();
    drive(1, 1, 0, 5'd2, 0, 0, 5'd1, 5'd31);
    check("alu_sel_s1", 32'(fwd_sel[1:0]), 32'd1); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd1, 5'd31);
    check("alu_sel_s2", 32'(fwd_sel[1:0]), 32'd2); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd1, 5'd31);
    check("alu_sel_s3", 32'(fwd_sel[1:0]), 32'd3); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd1, 5'd31);
    check("alu_sel_retired", 32'(fwd_sel[1:0]), 32'd0); tick();
    idle(3);

    // Shadowing: X5 at stages 3 and 1
    drive(1, 1, 0, 5'd5, 0, 0, 5'd31, 5'd31); tick();
    drive(1, 1, 0, 5'd6, 0, 0, 5'd31, 5'd31); tick();
    drive(1, 1, 0, 5'd5, 0, 0, 5'd31, 5'd31); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd31, 5'd5);
    check("shadow_sel1", 32'(fwd_sel[3:2]), 32'd1); tick();
    idle(3);

    // Load-use
    drive(1, 1, 1, 5'd3, 0, 0, 5'd31, 5'd31); tick();
    drive(1, 1, 0, 5'd4, 0, 0, 5'd3, 5'd31);
    check("ldu_hazard", 32'(hazard), 32'd1);
    check("ldu_sel_blocked", 32'(fwd_sel[1:0]), 32'd0); tick();
    drive(1, 1, 0, 5'd4, 0, 0, 5'd3, 5'd31);
    check("ldu_hazard_clear", 32'(hazard), 32'd0);
    check("ldu_sel_s2", 32'(fwd_sel[1:0]), 32'd2);
    check("ldu_bubble", 32'(inflight), 32'd1); tick();
    idle(3);

    // Zero register never matches; flushed issue leaves a bubble
    drive(1, 1, 0, 5'd31, 0, 0, 5'd31, 5'd31); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd31, 5'd31);
    check("xzr_sel0", 32'(fwd_sel[1:0]), 32'd0); tick();
    idle(3);
    drive(1, 1, 0, 5'd7, 0, 1, 5'd31, 5'd31); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd7, 5'd7);
    check("flush_sel0", 32'(fwd_sel[1:0]), 32'd0);
    check("flush_busy", 32'(busy), 32'd0); tick();
    drive(1, 1, 0, 5'd8, 1, 0, 5'd31, 5'd31); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd8, 5'd31);
    check("stall_sel0", 32'(fwd_sel[1:0]), 32'd0); tick();

    // Reset mid-stream with three entries valid
    drive(1, 1, 0, 5'd1, 0, 0, 5'd31, 5'd31); tick();
    drive(1, 1, 0, 5'd2, 0, 0, 5'd31, 5'd31); tick();
    drive(1, 1, 0, 5'd3, 0, 0, 5'd31, 5'd31); tick();
    rst_lvl = 1'b0;
    drive(0, 0, 0, 5'd0, 0, 0, 5'd1, 5'd2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_fwd_sel", 32'(fwd_sel), 32'd0); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd3, 5'd2); tick();
    rst_lvl = 1'b1;
    idle(1);

`ifdef FWD_SCOREBOARD_STATS_EN
    // Three forward cycles and one hazard cycle after a fresh reset
    drive(1, 1, 0, 5'd1, 0, 0, 5'd31, 5'd31); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 5'd0, 0, 0, 5'd1, 5'd31); tick();
    end
    drive(1, 1, 1, 5'd3, 0, 0, 5'd31, 5'd31); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd3, 5'd31); tick();
    drive(0, 0, 0, 5'd0, 0, 0, 5'd31, 5'd31);
    check("stat_fwd_3", 32'(stat_fwd_cnt), 32'd3);
    check("stat_hz_1", 32'(stat_hazard_cnt), 32'd1); tick();
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r0, r1, r2;
      r0 = $urandom_range(0, 8);
      r1 = $urandom_range(0, 8);
      r2 = $urandom_range(0, 8);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            (r0 == 8) ? 5'd31 : 5'(r0), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            (r1 == 8) ? 5'd31 : 5'(r1), (r2 == 8) ? 5'd31 : 5'(r2));
      tick();
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    begin
      int  hcount;
      int  cyc;
      bit  mid_done;
      hcount   = 0;
      mid_done = 1'b0;
      @(negedge clk);
      sat_reset = 1'b1;
      for (cyc = 0; cyc < 80000 && hcount < 70000; cyc++) begin
        @(negedge clk);
        #1;
        if (hcount == 40000 && !mid_done) begin
          mid_done = 1'b1;
          check("sat_mid_count", 32'(sat_hz_cnt), 32'd40000);
        end
        if (sat_hazard) hcount++;
      end
      check("sat_hazard_cycles_reached", 32'(hcount >= 70000), 32'd1);
      @(negedge clk);
      #1;
      check("sat_hazard_cnt", 32'(sat_hz_cnt), 32'h0000FFFF);
    end
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
